// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: control codes, ALUOp and
// funct decode keys, and the sequencer state type.
package alu_ctrl_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_NOP = 4'd0;
    localparam logic [CODE_W-1:0] CODE_AND = 4'd1;
    localparam logic [CODE_W-1:0] CODE_OR  = 4'd2;
    localparam logic [CODE_W-1:0] CODE_ADD = 4'd3;
    localparam logic [CODE_W-1:0] CODE_SUB = 4'd4;
    localparam logic [CODE_W-1:0] CODE_MUL = 4'd5;
    localparam logic [CODE_W-1:0] CODE_BRC = 4'd6;
    localparam logic [CODE_W-1:0] CODE_SLT = 4'd7;
    localparam logic [CODE_W-1:0] CODE_SLL = 4'd8;
    localparam logic [CODE_W-1:0] CODE_SRL = 4'd9;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_I   = 2'b10;

    // Full {funct7, funct3} keys for R-type
    localparam logic [9:0] FN_AND = 10'b0000000_111;
    localparam logic [9:0] FN_OR  = 10'b0000000_110;
    localparam logic [9:0] FN_ADD = 10'b0000000_000;
    localparam logic [9:0] FN_SUB = 10'b0100000_000;
    localparam logic [9:0] FN_MUL = 10'b0000001_000;
    localparam logic [9:0] FN_SLL = 10'b0000000_001;
    localparam logic [9:0] FN_SLT = 10'b0000000_010;
    localparam logic [9:0] FN_SRL = 10'b0000000_101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [6:0] F7_ZERO = 7'b0000000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALUOp/funct decode into a 4-bit ALU control code.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0]        alu_op,
    input  logic [9:0]        funct,
    output logic [CODE_W-1:0] code,
    output logic              illegal
);

    always_comb begin
        code    = CODE_NOP;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_R: begin
                case (funct)
                    FN_AND:  code = CODE_AND;
                    FN_OR:   code = CODE_OR;
                    FN_ADD:  code = CODE_ADD;
                    FN_SUB:  code = CODE_SUB;
                    FN_MUL:  code = CODE_MUL;
                    FN_SLL:  code = CODE_SLL;
                    FN_SLT:  code = CODE_SLT;
                    FN_SRL:  code = CODE_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_BR: code = CODE_BRC;
            ALUOP_I: begin
                // I-type ignores funct7 except to qualify the logical right shift
                case (funct[2:0])
                    F3_ADD: code = CODE_ADD;
                    F3_AND: code = CODE_AND;
                    F3_OR:  code = CODE_OR;
                    F3_SLT: code = CODE_SLT;
                    F3_SLL: code = CODE_SLL;
                    F3_SRL: begin
                        if (funct[9:3] == F7_ZERO) code = CODE_SRL;
                        else                       illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers decoded control codes and holds the ALU
// busy for MUL_CYCLES cycles on a multiply.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [9:0]        funct_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [CTRL_W-1:0] ALU_Ctrl_o,
    output logic              ctrl_valid_o,
    output logic              stall_o,
    output logic              mul_start_o,
    output logic              illegal_o
);

    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("alu_ctrl_seq: CTRL_W must be at least 4");
    end
    if (MUL_CYCLES < 1 || MUL_CYCLES > 16) begin : g_bad_mul_cycles
        $error("alu_ctrl_seq: MUL_CYCLES must be in 1..16");
    end

    localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] CNT_LOAD  = 4'(MUL_CYCLES - 1);

    logic [CODE_W-1:0] dec_code_p0;
    logic              dec_illegal_p0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              vld_q, vld_d;
    logic              ill_q, ill_d;
    logic              mstart_q, mstart_d;

    alu_ctrl_decode u_decode (
        .alu_op  (ALUOp_i),
        .funct   (funct_i),
        .code    (dec_code_p0),
        .illegal (dec_illegal_p0)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        vld_d    = 1'b0;
        ill_d    = 1'b0;
        mstart_d = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            ctrl_d  = CTRL_W'(CODE_NOP);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (!dec_illegal_p0 && dec_code_p0 == CODE_MUL && MUL_MULTI) begin
                            state_d  = ST_BUSY;
                            cnt_d    = CNT_LOAD;
                            ctrl_d   = CTRL_W'(CODE_MUL);
                            mstart_d = 1'b1;
                        end else begin
                            ctrl_d = CTRL_W'(dec_code_p0);
                            vld_d  = 1'b1;
                            ill_d  = dec_illegal_p0;
                        end
                    end
                end
                ST_BUSY: begin
                    // The cycle with cnt_q==0 is the last stalled one
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage p1: registered control outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ctrl_q   <= CTRL_W'(CODE_NOP);
            vld_q    <= 1'b0;
            ill_q    <= 1'b0;
            mstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            vld_q    <= vld_d;
            ill_q    <= ill_d;
            mstart_q <= mstart_d;
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign stall_o      = (state_q == ST_BUSY);
    assign ALU_Ctrl_o   = ctrl_q;
    assign ctrl_valid_o = vld_q;
    assign illegal_o    = ill_q;
    assign mul_start_o  = mstart_q;

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter CTRL_W, default 4: ALU control code width; elaboration error if below 4.
REQ-002 SHALL have parameter MUL_CYCLES, default 4: cycles a MUL occupies the ALU, legal range 1..16.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port valid_i, input, 1: a decode request is present this cycle.
REQ-006 SHALL have port ALUOp_i, input, 2: 00 R-type, 01 branch, 10 I-type, 11 reserved.
REQ-007 SHALL have port funct_i, input, 10: funct7 in bits 9:3, funct3 in bits 2:0.
REQ-008 SHALL have port flush_i, input, 1: abort any request or operation in flight.
REQ-009 SHALL have port ready_o, output, 1: a request is accepted this cycle.
REQ-010 SHALL have port ALU_Ctrl_o, output, CTRL_W: registered ALU control code.
REQ-011 SHALL have port ctrl_valid_o, output, 1: one-cycle pulse; ALU_Ctrl_o result is complete.
REQ-012 SHALL have port stall_o, output, 1: a multi-cycle operation is in progress.
REQ-013 SHALL have port mul_start_o, output, 1: one-cycle pulse on the first MUL cycle.
REQ-014 SHALL have port illegal_o, output, 1: pulses with ctrl_valid_o for an undecodable request.

Function
REQ-015 SHALL use codes NOP=0, AND=1, OR=2, ADD=3, SUB=4, MUL=5, BRC=6, SLT=7, SLL=8, SRL=9, zero-extended to CTRL_W.
REQ-016 SHALL decode ALUOp 00 on the full funct: 0000000_111 AND, 0000000_110 OR, 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL, 0000000_001 SLL, 0000000_010 SLT, 0000000_101 SRL; all other values are illegal.
REQ-017 SHALL decode ALUOp 01 as BRC regardless of funct.
REQ-018 SHALL decode ALUOp 10 on funct3: 000 ADD, 111 AND, 110 OR, 010 SLT, 001 SLL; 101 SRL only when funct7=0000000; all other values are illegal.
REQ-019 SHALL treat ALUOp 11 as illegal.
REQ-020 SHALL produce NOP code with illegal_o=1 for any illegal request.
REQ-021 SHALL implement FSM states IDLE and BUSY.
REQ-022 SHALL drive ready_o=1 in IDLE and ready_o=0 in BUSY.
REQ-023 SHALL, on acceptance of a non-MUL request (or MUL with MUL_CYCLES=1), register the code and pulse ctrl_valid_o on the next cycle (latency 1), remaining in IDLE.
REQ-024 SHALL, on acceptance of MUL with MUL_CYCLES>1, enter BUSY next cycle with ALU_Ctrl_o=MUL, stall_o=1, mul_start_o=1 in that cycle only, and counter loaded with MUL_CYCLES-1.
REQ-025 SHALL decrement the counter each BUSY cycle; when it reaches 0, pulse ctrl_valid_o for one cycle, deassert stall_o, and return to IDLE.
REQ-026 SHALL hold ALU_Ctrl_o=MUL throughout BUSY and hold ALU_Ctrl_o after a pulse until the next accepted request or flush.
REQ-027 SHALL ignore valid_i while in BUSY.
REQ-028 SHALL accept a new request in the same cycle the FSM returns to IDLE (back-to-back throughput).
REQ-029 SHALL give flush_i priority over valid_i: next cycle IDLE, counter=0, ALU_Ctrl_o=NOP, and no ctrl_valid_o, illegal_o or mul_start_o pulse.

Reset
REQ-030 SHALL, while rst_n_i=0, immediately force IDLE, counter=0, ALU_Ctrl_o=NOP, ctrl_valid_o=0, stall_o=0, mul_start_o=0, illegal_o=0; ready_o then reads 1.
REQ-031 SHALL abort a BUSY operation when reset asserts mid-operation, with no completion pulse after release.

Structure
REQ-032 SHALL place the code constants, funct keys and FSM state type in shared package alu_ctrl_pkg.
REQ-033 SHALL isolate the combinational decode in one sub-module, alu_ctrl_decode (ALUOp/funct in; code and illegal out).

Verification
REQ-034 SHALL cover: valid_i with ALUOp 00, funct 0100000000 -> next cycle ALU_Ctrl_o=4, ctrl_valid_o=1 for one cycle.
REQ-035 SHALL cover: MUL (0000001000) with MUL_CYCLES=4 -> stall_o high 4 cycles, mul_start_o on the first, ctrl_valid_o on the cycle after the last, ready_o=0 throughout BUSY.
REQ-036 SHALL cover: ALUOp 11, then ALUOp 10 with funct 0100000101 -> each gives ALU_Ctrl_o=0, illegal_o=1, ctrl_valid_o=1.
REQ-037 SHALL cover: flush_i asserted during the 2nd BUSY cycle together with valid_i -> IDLE next cycle, ALU_Ctrl_o=0, no ctrl_valid_o pulse.
REQ-038 SHALL cover: rst_n_i low mid-MUL, asynchronous to clk_i -> outputs clear immediately; after release ready_o=1 and no pulses.
REQ-039 SHALL cover: MUL_CYCLES=1, MUL then ADD back-to-back -> codes 5 then 3 on consecutive cycles, stall_o never asserted.
